// File: rtl/soc_addr_map_decoder.sv
// soc_addr_map_decoder
// Runtime-programmable address decoder placed between the CPU master port and
// the crossbar slave select. A small table of {base, length, valid} rules is
// written through a simple strobe-based config port and can be locked until
// the next reset. Request addresses are decoded combinationally against the
// table and registered into a single output stage that carries the matched
// slave index or a decode error. Decode misses are counted with saturation.

module soc_addr_map_decoder #(
   parameter  int unsigned NrRules    = 11,
   parameter  int unsigned AddrWidth  = 64,
   parameter  int unsigned DefaultIdx = 0,
   parameter  int unsigned CntWidth   = 16,
   localparam int unsigned IdxWidth   = (NrRules > 1) ? $clog2(NrRules) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,

   // Config port: single-cycle write strobe, no handshake.
   input  logic                 cfg_we_i,
   input  logic [IdxWidth-1:0]  cfg_idx_i,
   input  logic [AddrWidth-1:0] cfg_base_i,
   input  logic [AddrWidth-1:0] cfg_len_i,
   input  logic                 cfg_valid_i,
   input  logic                 cfg_lock_i,
   output logic                 cfg_err_o,
   output logic                 locked_o,

   // Decode request / response streams.
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [AddrWidth-1:0] req_addr_i,
   output logic                 resp_valid_o,
   input  logic                 resp_ready_i,
   output logic [IdxWidth-1:0]  resp_idx_o,
   output logic                 resp_err_o,
   output logic [CntWidth-1:0]  err_cnt_o
);

   // Highest legal rule index; anything above it addresses no rule.
   localparam logic [IdxWidth-1:0] LastIdx    = IdxWidth'(NrRules - 1);
   localparam logic [IdxWidth-1:0] DefIdx     = IdxWidth'(DefaultIdx);
   localparam logic [CntWidth-1:0] CntSatVal  = {CntWidth{1'b1}};

   // ------------------------------------------------------------------
   // Rule table and config state
   // ------------------------------------------------------------------
   logic [AddrWidth-1:0] r_base  [NrRules];
   logic [AddrWidth-1:0] r_len   [NrRules];
   logic [NrRules-1:0]   r_valid;
   logic                 r_locked;
   logic                 r_cfg_err;

   logic w_idx_ok;
   logic w_cfg_wr;
   logic w_cfg_reject;

   assign w_idx_ok     = (cfg_idx_i <= LastIdx);
   // A write lands only while unlocked and aimed at an existing rule; the
   // lock check uses the registered lock, so a write issued together with
   // cfg_lock_i is still applied.
   assign w_cfg_wr     = cfg_we_i && !r_locked && w_idx_ok;
   assign w_cfg_reject = cfg_we_i && (r_locked || !w_idx_ok);

   // Rule table update: one rule written per accepted config strobe.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(NrRules); i++) begin
            r_base[i]  <= '0;
            r_len[i]   <= '0;
            r_valid[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < int'(NrRules); i++) begin
            if (w_cfg_wr && (cfg_idx_i == IdxWidth'(i))) begin
               r_base[i]  <= cfg_base_i;
               r_len[i]   <= cfg_len_i;
               r_valid[i] <= cfg_valid_i;
            end
         end
      end
   end

   // Sticky lock and one-cycle rejected-write pulse.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_locked  <= 1'b0;
         r_cfg_err <= 1'b0;
      end else begin
         r_cfg_err <= w_cfg_reject;
         if (cfg_lock_i) begin
            r_locked <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Address match
   // ------------------------------------------------------------------
   // Each rule is checked as addr >= base && (addr - base) < len. The
   // subtraction is only meaningful when addr >= base, and no base+len sum
   // is ever formed, so a rule that ends exactly at the top of the address
   // space cannot wrap around to cover low addresses. len = 0 never matches.
   logic [AddrWidth-1:0] w_offset [NrRules];
   logic [NrRules-1:0]   w_hit;

   for (genvar g = 0; g < int'(NrRules); g++) begin : g_match
      assign w_offset[g] = req_addr_i - r_base[g];
      assign w_hit[g]    = r_valid[g]
                        && (req_addr_i >= r_base[g])
                        && (w_offset[g] < r_len[g]);
   end

   logic                w_hit_any;
   logic [IdxWidth-1:0] w_hit_idx;

   // Priority select: scan from the top so the lowest matching index wins.
   always_comb begin
      w_hit_any = 1'b0;
      w_hit_idx = DefIdx;
      for (int i = int'(NrRules) - 1; i >= 0; i--) begin
         if (w_hit[i]) begin
            w_hit_any = 1'b1;
            w_hit_idx = IdxWidth'(i);
         end
      end
   end

   // ------------------------------------------------------------------
   // Output register stage
   // ------------------------------------------------------------------
   // Handshake: a transfer happens on a rising edge where valid and ready
   // are both high. The producer holds valid (and its payload) until that
   // edge; ready may depend combinationally on the consumer's ready.
   // Here req_ready_o = !resp_valid_o || resp_ready_i, so a held response
   // frees the register in the same cycle it is accepted and back-to-back
   // requests flow at one decode per cycle.
   logic                r_resp_valid;
   logic [IdxWidth-1:0] r_resp_idx;
   logic                r_resp_err;
   logic [CntWidth-1:0] r_err_cnt;

   logic w_req_ready;
   logic w_req_fire;

   assign w_req_ready = !r_resp_valid || resp_ready_i;
   assign w_req_fire  = req_valid_i && w_req_ready;

   // Response register: load on accepted request, clear when drained.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_resp_valid <= 1'b0;
         r_resp_idx   <= DefIdx;
         r_resp_err   <= 1'b0;
      end else if (w_req_fire) begin
         r_resp_valid <= 1'b1;
         r_resp_idx   <= w_hit_any ? w_hit_idx : DefIdx;
         r_resp_err   <= !w_hit_any;
      end else if (resp_ready_i) begin
         r_resp_valid <= 1'b0;
      end
   end

   // Decode-error counter: counts misses entering the register, saturating.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_err_cnt <= '0;
      end else if (w_req_fire && !w_hit_any && (r_err_cnt != CntSatVal)) begin
         r_err_cnt <= r_err_cnt + 1'b1;
      end
   end

   assign req_ready_o  = w_req_ready;
   assign resp_valid_o = r_resp_valid;
   assign resp_idx_o   = r_resp_idx;
   assign resp_err_o   = r_resp_err;
   assign err_cnt_o    = r_err_cnt;
   assign cfg_err_o    = r_cfg_err;
   assign locked_o     = r_locked;

endmodule

// File: tb/tb_soc_addr_map_decoder.sv
// tb_soc_addr_map_decoder
// Cycle-level bench: inputs are driven at the falling edge, outputs are
// compared 1 ns later against a reference model that keeps the rule table in
// plain arrays, decodes with 65-bit end-address arithmetic and tracks the
// response register as an expected queue.

module tb_soc_addr_map_decoder;

   localparam int N_RULES = 11;
   localparam int AW      = 64;
   localparam int IW      = 4;
   localparam int CW      = 2;

   // Clock / reset
   logic clk = 1'b0;
   logic rst_i;
   always #5 clk = ~clk;

   // DUT signals
   logic          cfg_we_i;
   logic [IW-1:0] cfg_idx_i;
   logic [AW-1:0] cfg_base_i;
   logic [AW-1:0] cfg_len_i;
   logic          cfg_valid_i;
   logic          cfg_lock_i;
   logic          cfg_err_o;
   logic          locked_o;
   logic          req_valid_i;
   logic          req_ready_o;
   logic [AW-1:0] req_addr_i;
   logic          resp_valid_o;
   logic          resp_ready_i;
   logic [IW-1:0] resp_idx_o;
   logic          resp_err_o;
   logic [CW-1:0] err_cnt_o;

   soc_addr_map_decoder #(
      .NrRules    (N_RULES),
      .AddrWidth  (AW),
      .DefaultIdx (0),
      .CntWidth   (CW)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .cfg_we_i     (cfg_we_i),
      .cfg_idx_i    (cfg_idx_i),
      .cfg_base_i   (cfg_base_i),
      .cfg_len_i    (cfg_len_i),
      .cfg_valid_i  (cfg_valid_i),
      .cfg_lock_i   (cfg_lock_i),
      .cfg_err_o    (cfg_err_o),
      .locked_o     (locked_o),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_addr_i   (req_addr_i),
      .resp_valid_o (resp_valid_o),
      .resp_ready_i (resp_ready_i),
      .resp_idx_o   (resp_idx_o),
      .resp_err_o   (resp_err_o),
      .err_cnt_o    (err_cnt_o)
   );

   // Reference model state
   logic [AW-1:0] m_base  [N_RULES];
   logic [AW-1:0] m_len   [N_RULES];
   logic          m_valid [N_RULES];
   logic          m_locked;
   logic          m_cfg_err;
   int            m_cnt;
   logic [IW:0]   exp_q[$];   // {err, idx} of responses not yet handed over

   int checks   = 0;
   int failures = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < N_RULES; i++) begin
         m_base[i]  = '0;
         m_len[i]   = '0;
         m_valid[i] = 1'b0;
      end
      m_locked  = 1'b0;
      m_cfg_err = 1'b0;
      m_cnt     = 0;
      exp_q.delete();
   endfunction

   // Address belongs to rule i when base <= addr < base + len, with the end
   // computed one bit wider so a rule ending at 2^64 stays at the top.
   function automatic logic [IW:0] ref_decode(input logic [AW-1:0] a);
      logic [AW:0] end_excl;
      for (int i = 0; i < N_RULES; i++) begin
         end_excl = {1'b0, m_base[i]} + {1'b0, m_len[i]};
         if (m_valid[i] && ({1'b0, a} >= {1'b0, m_base[i]}) && ({1'b0, a} < end_excl))
            return {1'b0, IW'(i)};
      end
      return {1'b1, {IW{1'b0}}};
   endfunction

   // One clock: compare outputs, advance the model, step to the next falling edge.
   task automatic cycle();
      logic        exp_ready;
      logic [IW:0] d;
      #1;
      exp_ready = (exp_q.size() == 0) || resp_ready_i;
      check_val("req_ready", req_ready_o, exp_ready);
      check_val("resp_valid", resp_valid_o, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
         check_val("resp_idx", resp_idx_o, exp_q[0][IW-1:0]);
         check_val("resp_err", resp_err_o, exp_q[0][IW]);
      end
      check_val("err_cnt", err_cnt_o, m_cnt);
      check_val("locked", locked_o, m_locked);
      check_val("cfg_err", cfg_err_o, m_cfg_err);

      if (rst_i) begin
         model_reset();
      end else begin
         if (exp_q.size() != 0 && resp_ready_i) void'(exp_q.pop_front());
         if (req_valid_i && exp_ready) begin
            d = ref_decode(req_addr_i);
            exp_q.push_back(d);
            if (d[IW] && m_cnt < (2**CW - 1)) m_cnt++;
         end
         m_cfg_err = cfg_we_i && (m_locked || int'(cfg_idx_i) >= N_RULES);
         if (cfg_we_i && !m_locked && int'(cfg_idx_i) < N_RULES) begin
            m_base[cfg_idx_i]  = cfg_base_i;
            m_len[cfg_idx_i]   = cfg_len_i;
            m_valid[cfg_idx_i] = cfg_valid_i;
         end
         if (cfg_lock_i) m_locked = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   // Driver tasks
   task automatic cfg_write(input int idx, input logic [AW-1:0] base,
                            input logic [AW-1:0] len, input logic v);
      cfg_we_i    = 1'b1;
      cfg_idx_i   = IW'(idx);
      cfg_base_i  = base;
      cfg_len_i   = len;
      cfg_valid_i = v;
      cycle();
      cfg_we_i    = 1'b0;
   endtask

   task automatic send(input logic [AW-1:0] a);
      req_valid_i = 1'b1;
      req_addr_i  = a;
      cycle();
      req_valid_i = 1'b0;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      cycle();
      rst_i = 1'b0;
   endtask

   function automatic logic [AW-1:0] rand_addr();
      int          r;
      logic [AW-1:0] a;
      a = {$urandom(), $urandom()};
      if ($urandom_range(0, 1) == 1) begin
         r = $urandom_range(0, N_RULES - 1);
         case ($urandom_range(0, 3))
            0: a = m_base[r];
            1: a = m_base[r] + m_len[r] - 1;
            2: a = m_base[r] + m_len[r];
            default: a = m_base[r] + AW'($urandom_range(0, 255));
         endcase
      end
      return a;
   endfunction

   initial begin
      logic [IW-1:0] held_idx;

      rst_i = 1'b1;
      cfg_we_i = 1'b0; cfg_idx_i = '0; cfg_base_i = '0; cfg_len_i = '0;
      cfg_valid_i = 1'b0; cfg_lock_i = 1'b0;
      req_valid_i = 1'b0; req_addr_i = '0; resp_ready_i = 1'b1;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_i = 1'b0;

      // Reset values
      check_val("rst_resp_idx", resp_idx_o, 0);
      check_val("rst_resp_err", resp_err_o, 0);
      check_val("rst_resp_valid", resp_valid_o, 0);
      check_val("rst_cnt", err_cnt_o, 0);

      // Single rule: last byte hits, first byte past the end misses
      cfg_write(5, 64'h0000_0000_1000_0000, 64'h1000, 1'b1);
      send(64'h0000_0000_1000_0FFF);
      check_val("t1_hit_idx", resp_idx_o, 5);
      check_val("t1_hit_err", resp_err_o, 0);
      send(64'h0000_0000_1000_1000);
      check_val("t1_miss_idx", resp_idx_o, 0);
      check_val("t1_miss_err", resp_err_o, 1);
      check_val("t1_miss_cnt", err_cnt_o, 1);

      // Overlap: rule0 covers rule9's base, lowest index wins
      cfg_write(0, 64'h0, 64'h1_0000_0000, 1'b1);
      cfg_write(9, 64'h8000_0000, 64'h4000_0000, 1'b1);
      send(64'h8000_0000);
      check_val("t2_prio_idx", resp_idx_o, 0);
      check_val("t2_prio_err", resp_err_o, 0);

      // Top-of-space rule must not wrap to address 0
      cfg_write(0, 64'h0, 64'h0, 1'b0);
      cfg_write(10, 64'hFFFF_FFFF_FFFF_F000, 64'h1000, 1'b1);
      send(64'hFFFF_FFFF_FFFF_FFFF);
      check_val("t4_top_idx", resp_idx_o, 10);
      check_val("t4_top_err", resp_err_o, 0);
      send(64'h0);
      check_val("t4_zero_err", resp_err_o, 1);
      check_val("t4_zero_idx", resp_idx_o, 0);
      cycle();

      // Randomized traffic, config writes including out-of-range indices
      for (int n = 0; n < 400; n++) begin
         req_valid_i  = ($urandom_range(0, 3) != 0);
         resp_ready_i = ($urandom_range(0, 2) != 0);
         req_addr_i   = rand_addr();
         cfg_we_i     = ($urandom_range(0, 7) == 0);
         cfg_idx_i    = IW'($urandom_range(0, 15));
         cfg_base_i   = {$urandom(), $urandom()};
         if ($urandom_range(0, 1) == 1) cfg_base_i[63:32] = '0;
         case ($urandom_range(0, 3))
            0: cfg_len_i = '0;
            1: cfg_len_i = AW'($urandom_range(1, 4096));
            2: cfg_len_i = {32'h0, $urandom()};
            default: cfg_len_i = {$urandom(), $urandom()};
         endcase
         cfg_valid_i  = ($urandom_range(0, 3) != 0);
         cycle();
      end
      cfg_we_i = 1'b0;
      req_valid_i = 1'b0;
      resp_ready_i = 1'b1;
      cycle();
      cycle();

      // Backpressure: three stalled cycles, then stream without loss
      resp_ready_i = 1'b0;
      send(64'h0000_0000_1000_0010);
      held_idx = resp_idx_o;
      for (int n = 0; n < 3; n++) begin
         req_valid_i = 1'b1;
         req_addr_i  = 64'h8000_0000 + AW'(n);
         cycle();
         check_val("t3_stall_ready", req_ready_o, 0);
         check_val("t3_stall_idx", resp_idx_o, held_idx);
      end
      resp_ready_i = 1'b1;
      for (int n = 0; n < 5; n++) begin
         req_addr_i = ($urandom_range(0, 1) == 1) ? 64'h0000_0000_1000_0100 : rand_addr();
         cycle();
      end
      req_valid_i = 1'b0;
      cycle();
      check_val("t3_drained", resp_valid_o, 0);

      // Bad index unlocked, then lock and attempt to rewrite rule3
      cfg_write(11, 64'h4000, 64'h10, 1'b1);
      check_val("t5_badidx_err", cfg_err_o, 1);
      cfg_write(3, 64'h2000_0000, 64'h100, 1'b1);
      check_val("t5_goodwr_err", cfg_err_o, 0);
      cfg_lock_i = 1'b1;
      cycle();
      cfg_lock_i = 1'b0;
      check_val("t5_locked", locked_o, 1);
      cfg_write(3, 64'h3000_0000, 64'h100, 1'b1);
      check_val("t5_locked_err", cfg_err_o, 1);
      cycle();
      check_val("t5_err_pulse", cfg_err_o, 0);
      send(64'h2000_0010);
      check_val("t5_rule3_kept", resp_idx_o, 3);
      check_val("t5_rule3_err", resp_err_o, 0);
      cycle();

      // Saturating counter, then reset with a response in flight
      do_reset();
      check_val("t6_cnt_clr", err_cnt_o, 0);
      for (int n = 0; n < 5; n++) send(64'h5 + AW'(n));
      check_val("t6_cnt_sat", err_cnt_o, 3);
      resp_ready_i = 1'b0;
      cfg_lock_i = 1'b1;
      send(64'h77);
      cfg_lock_i = 1'b0;
      check_val("t6_inflight", resp_valid_o, 1);
      check_val("t6_locked_pre", locked_o, 1);
      do_reset();
      resp_ready_i = 1'b1;
      check_val("t6_rst_valid", resp_valid_o, 0);
      check_val("t6_rst_cnt", err_cnt_o, 0);
      check_val("t6_rst_locked", locked_o, 0);
      check_val("t6_rst_idx", resp_idx_o, 0);
      cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
